conv_tile_scheduler: RTL

Sequences the existing 4x4-window / 3x3-kernel `single_process_array` over an 8x8 feature map to produce a full 6x6 valid-convolution result. The scheduler holds the image and kernel in local registers, which the host loads byte by byte. It steps nine overlapping 4x4 tiles (stride 2) through the array and scatters each 2x2 result into a 36-byte output buffer that the host can read. The scheduler sits between the host/control bus and one external `single_process_array` instance.

---
 rtl/conv_pkg.sv | 34 +++
 rtl/conv_result_buf.sv | 35 +++
 rtl/conv_tile_scheduler.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and address helpers for the convolution tile scheduler.
package conv_pkg;
  localparam int IMG_DIM       = 8;
  localparam int KER_DIM       = 3;
  localparam int WIN_DIM       = 4;
  localparam int OUT_DIM       = 6;
  localparam int TILES         = 9;
  localparam int STRIDE        = 2;
  localparam int TILES_PER_ROW = (IMG_DIM - WIN_DIM) / STRIDE + 1;
  localparam int RES_TILE      = WIN_DIM - KER_DIM + 1;
  localparam int RES_BYTES     = OUT_DIM * OUT_DIM;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, GAP, DONE} state_e;

  function automatic int tile_row(input logic [3:0] t);
    return int'(t) / TILES_PER_ROW;
  endfunction

  function automatic int tile_col(input logic [3:0] t);
    return int'(t) % TILES_PER_ROW;
  endfunction

  function automatic logic [5:0] img_addr(input int row, input int col);
    int a;
    a = row * IMG_DIM + col;
    return a[5:0];
  endfunction

  function automatic logic [5:0] res_addr(input int row, input int col);
    int a;
    a = row * OUT_DIM + col;
    return a[5:0];
  endfunction
endpackage

// File: rtl/conv_result_buf.sv
// 6x6 result store: one 2x2 block written per capture at (wr_row, wr_col), combinational read.
module conv_result_buf import conv_pkg::*; #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [2:0]      wr_row,
  input  logic [2:0]      wr_col,
  input  logic [4*DW-1:0] wr_data,
  input  logic [5:0]      rd_addr,
  output logic [DW-1:0]   rd_data
);
  logic [DW-1:0] mem_q [RES_BYTES];
  logic [DW-1:0] mem_d [RES_BYTES];

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    mem_d = mem_q;
    if (wr_en) begin
      for (int i = 0; i < RES_TILE; i++)
        for (int j = 0; j < RES_TILE; j++)
          mem_d[res_addr(int'(wr_row) + i, int'(wr_col) + j)] = wr_data[(i*RES_TILE + j)*DW +: DW];
    end
  end

  // NOTE: storage is reset too, because the host may read results before any job has run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '{default: '0};
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    else     mem_q <= mem_d;
  end

  assign rd_data = (int'(rd_addr) < RES_BYTES) ? mem_q[rd_addr] : '0;
endmodule

// File: rtl/conv_tile_scheduler.sv
// Steps nine stride-2 4x4 tiles of an 8x8 image through an external 3x3 single_process_array.
// Define SCHED_TIMEOUT_EN to abort a tile whose done_single does not arrive within TIMEOUT RUN cycles.
module conv_tile_scheduler import conv_pkg::*; #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [5:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic [5:0]    rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          active_single,
  output logic [DW-1:0] a11, a12, a13, a14, a21, a22, a23, a24,
  output logic [DW-1:0] a31, a32, a33, a34, a41, a42, a43, a44,
  output logic [DW-1:0] b11, b12, b13, b21, b22, b23, b31, b32, b33,
  input  logic          done_single,
  input  logic [DW-1:0] c11, c12, c21, c22
);
  logic [DW-1:0] img_q  [IMG_DIM*IMG_DIM];
  logic [DW-1:0] img_d  [IMG_DIM*IMG_DIM];
  logic [DW-1:0] ker_q  [KER_DIM*KER_DIM];
  logic [DW-1:0] ker_d  [KER_DIM*KER_DIM];
  logic [DW-1:0] win_q  [WIN_DIM*WIN_DIM];
  logic [DW-1:0] win_d  [WIN_DIM*WIN_DIM];
  logic [DW-1:0] kout_q [KER_DIM*KER_DIM];
  logic [DW-1:0] kout_d [KER_DIM*KER_DIM];
  state_e        state_q, state_d;
  logic [3:0]    tile_q, tile_d;
  logic          busy_q, busy_d, done_q, done_d, active_q, active_d;
  logic          cap_en;
  logic [2:0]    cap_row, cap_col;
`ifdef SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] run_cnt_q, run_cnt_d;
  logic          err_q, err_d;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  always_comb begin
    state_d  = state_q;
    tile_d   = tile_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    active_d = active_q;
    img_d    = img_q;
    ker_d    = ker_q;
    win_d    = win_q;
    kout_d   = kout_q;
    cap_en   = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    run_cnt_d = run_cnt_q;
    err_d     = err_q;
`endif
    // Host writes share the IDLE edge with start, so LOAD already sees them.
    if (wr_en && !busy_q) begin
      if (!wr_sel)                                img_d[wr_addr]      = wr_data;
      else if (int'(wr_addr) < KER_DIM * KER_DIM) ker_d[wr_addr[3:0]] = wr_data;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          busy_d  = 1'b1;
`ifdef SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      LOAD: begin
        for (int i = 0; i < WIN_DIM; i++)
          for (int j = 0; j < WIN_DIM; j++)
            win_d[i*WIN_DIM + j] =
              img_q[img_addr(STRIDE*tile_row(tile_q) + i, STRIDE*tile_col(tile_q) + j)];
        kout_d   = ker_q;
        active_d = 1'b1;
        state_d  = RUN;
`ifdef SCHED_TIMEOUT_EN
        run_cnt_d = '0;
`endif
      end
      RUN: begin
        if (done_single) begin
          cap_en   = 1'b1;
          active_d = 1'b0;
          state_d  = GAP;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (run_cnt_q == CW'(TIMEOUT - 1)) begin
          err_d    = 1'b1;
          active_d = 1'b0;
          busy_d   = 1'b0;
          tile_d   = '0;
          state_d  = IDLE;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
`endif
      end
      GAP: begin
        if (tile_q == 4'(TILES - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          tile_d  = tile_q + 1'b1;
          state_d = LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        tile_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tile_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
      img_q    <= '{default: '0};
      ker_q    <= '{default: '0};
      win_q    <= '{default: '0};
      kout_q   <= '{default: '0};
`ifdef SCHED_TIMEOUT_EN
      run_cnt_q <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tile_q   <= tile_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      active_q <= active_d;
      img_q    <= img_d;
      ker_q    <= ker_d;
      win_q    <= win_d;
      kout_q   <= kout_d;
`ifdef SCHED_TIMEOUT_EN
      run_cnt_q <= run_cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign cap_row = 3'(STRIDE * tile_row(tile_q));
  assign cap_col = 3'(STRIDE * tile_col(tile_q));

  conv_result_buf #(.DW(DW)) u_result_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cap_en),
    .wr_row  (cap_row),
    .wr_col  (cap_col),
    .wr_data ({c22, c21, c12, c11}),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign active_single = active_q;
`ifdef SCHED_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign {a11, a12, a13, a14} = {win_q[0],  win_q[1],  win_q[2],  win_q[3]};
  assign {a21, a22, a23, a24} = {win_q[4],  win_q[5],  win_q[6],  win_q[7]};
  assign {a31, a32, a33, a34} = {win_q[8],  win_q[9],  win_q[10], win_q[11]};
  assign {a41, a42, a43, a44} = {win_q[12], win_q[13], win_q[14], win_q[15]};
  assign {b11, b12, b13}      = {kout_q[0], kout_q[1], kout_q[2]};
  assign {b21, b22, b23}      = {kout_q[3], kout_q[4], kout_q[5]};
  assign {b31, b32, b33}      = {kout_q[6], kout_q[7], kout_q[8]};
endmodule
